instr_cache: RTL and testbench

INSTR_CACHE -- requirements
Module: instr_cache

---
 rtl/instr_cache.sv | 124 ++++++++++++
 tb/tb_instr_cache.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines x 16 bytes over a 1 KiB space.
// Hits return the word combinationally; misses fetch one block through IDLE/FETCH/UPDATE.
module instr_cache (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  pc_i,
   output logic [31:0]  instruction_o,
   output logic         busywait_o,
   output logic         mem_read_o,
   output logic [5:0]   mem_address_o,
   input  logic [127:0] mem_readdata_i,
   input  logic         mem_busywait_i
);

   localparam int unsigned NUM_LINES = 8;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned TAG_W     = 3;
   localparam int unsigned OFF_W     = 2;
   localparam int unsigned BLK_W     = IDX_W + TAG_W;
   localparam int unsigned LINE_W    = 128;
   localparam int unsigned WORD_W    = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_UPDATE
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NUM_LINES];
   logic [LINE_W-1:0]   data_q [NUM_LINES];
   logic [BLK_W-1:0]    fetch_addr_q, fetch_addr_d;
   logic [LINE_W-1:0]   blk_q, blk_d;
   logic                mem_read_q, mem_read_d;
   logic [BLK_W-1:0]    mem_addr_q, mem_addr_d;

   logic [TAG_W-1:0]    pc_tag;
   logic [IDX_W-1:0]    pc_idx;
   logic [OFF_W-1:0]    pc_off;
   logic [LINE_W-1:0]   sel_line;
   logic                hit_c;
   logic                fill_c;
   logic                unused_pc;

   // PC bits outside the 1 KiB window alias; byte-within-word bits are ignored
   assign unused_pc = ^{pc_i[31:10], pc_i[1:0]};

   assign pc_tag   = pc_i[9:7];
   assign pc_idx   = pc_i[6:4];
   assign pc_off   = pc_i[3:2];
   assign sel_line = data_q[pc_idx];
   assign hit_c    = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

   assign instruction_o = sel_line[{pc_off, 5'd0} +: WORD_W];
   assign mem_read_o    = mem_read_q;
   assign mem_address_o = mem_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         fetch_addr_q <= '0;
         mem_read_q   <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         mem_read_q   <= mem_read_d;
         mem_addr_q   <= mem_addr_d;
         if (fill_c) begin
            valid_q[fetch_addr_q[IDX_W-1:0]] <= 1'b1;
         end
      end
   end

   // Tag/data arrays carry no reset; valid bits alone gate hits
   always_ff @(posedge clk) begin
      blk_q <= blk_d;
      if (fill_c) begin
         data_q[fetch_addr_q[IDX_W-1:0]] <= blk_q;
         tag_q[fetch_addr_q[IDX_W-1:0]]  <= fetch_addr_q[BLK_W-1:IDX_W];
      end
   end

   // mem_read/mem_address are registered, so they are computed for the next state
   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      blk_d        = blk_q;
      mem_read_d   = 1'b0;
      mem_addr_d   = '0;
      fill_c       = 1'b0;
      busywait_o   = 1'b1;
      case (state_q)
         S_IDLE: begin
            busywait_o = ~hit_c;
            if (!hit_c) begin
               state_d      = S_FETCH;
               fetch_addr_d = pc_i[9:4];
               mem_read_d   = 1'b1;
               mem_addr_d   = pc_i[9:4];
            end
         end
         S_FETCH: begin
            if (mem_busywait_i) begin
               mem_read_d = 1'b1;
               mem_addr_d = fetch_addr_q;
            end else begin
               state_d = S_UPDATE;
               blk_d   = mem_readdata_i;
            end
         end
         S_UPDATE: begin
            fill_c  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: fetches queue expected words, stall counts and block fills;
// a negedge monitor compares them as the cache responds.
module tb_instr_cache;

   logic         clk;
   logic         rst_n;
   logic [31:0]  pc;
   logic [31:0]  instruction;
   logic         busywait;
   logic         mem_read;
   logic [5:0]   mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      int          busy;
   } exp_t;

   exp_t       exp_q[$];
   logic [5:0] fill_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         n_done = 0;
   int         busy_cnt = 0;
   logic       prev_rd = 1'b0;
   int         lat = 3;
   int         mem_cnt = 0;

   instr_cache dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_i           (pc),
      .instruction_o  (instruction),
      .busywait_o     (busywait),
      .mem_read_o     (mem_read),
      .mem_address_o  (mem_address),
      .mem_readdata_i (mem_readdata),
      .mem_busywait_i (mem_busywait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [7:0] i);
      return 32'h0001_0003 + (32'(i) << 20);
   endfunction

   function automatic logic [127:0] mem_block(input logic [5:0] b);
      logic [127:0] blk;
      for (int w = 0; w < 4; w++) begin
         logic [1:0] w2;
         w2 = w[1:0];
         blk[32*w +: 32] = mem_word({b, w2});
      end
      return blk;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory: a read lasts 'lat' FETCH cycles; busywait is high for all but the last one
   always @(posedge clk) begin
      #1;
      mem_readdata = mem_block(mem_address);
      if (mem_read) begin
         mem_busywait = (mem_cnt < lat - 1);
         mem_cnt++;
      end else begin
         mem_busywait = 1'b0;
         mem_cnt = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
         prev_rd  = 1'b0;
      end else begin
         if (!mem_read) check("addr_idle_zero", 64'(mem_address), 64'd0);
         if (mem_read && !prev_rd) begin
            if (fill_q.size() == 0) begin
               check("unexpected_fill", 64'(mem_address), 64'hFF);
            end else begin
               logic [5:0] fa;
               fa = fill_q.pop_front();
               check("fill_addr", 64'(mem_address), 64'(fa));
            end
         end
         prev_rd = mem_read;
         if (exp_q.size() == 0) begin
            busy_cnt = 0;
         end else if (busywait) begin
            busy_cnt++;
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("instr@%0h", e.pc), 64'(instruction), 64'(e.ins));
            check($sformatf("busy@%0h", e.pc), 64'(busy_cnt), 64'(e.busy));
            busy_cnt = 0;
            n_done++;
         end
      end
   end

   task automatic fetch(input logic [31:0] a, input logic [31:0] ins, input int busy,
                        input bit fills, input logic [5:0] fa);
      exp_t e;
      int   start;
      e.pc = a; e.ins = ins; e.busy = busy;
      if (fills) fill_q.push_back(fa);
      exp_q.push_back(e);
      start = n_done;
      pc = a;
      for (int c = 0; c < 60 && n_done == start; c++) @(posedge clk);
      if (n_done == start) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout@%0h: no response within 60 cycles", a);
         exp_q.delete();
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst_mem_read", 64'(mem_read), 64'd0);
      check("rst_mem_addr", 64'(mem_address), 64'd0);
      check("rst_busywait", 64'(busywait), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_mem_read();
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (mem_read) return;
      end
      check("mem_read_rise", 64'(mem_read), 64'd1);
   endtask

   initial begin
      logic [31:0] pa;
      bit          miss;
      rst_n = 1'b0;
      pc = 32'h0;
      mem_readdata = '0;
      mem_busywait = 1'b0;
      @(posedge clk);
      #1;

      // Cold miss with a 3-cycle memory, then spatial hits in block 0
      lat = 3;
      do_reset();
      fetch(32'h0000_0000, 32'h0001_0003, 5, 1'b1, 6'h00);
      fetch(32'h0000_0004, 32'h0011_0003, 0, 1'b0, 6'h00);
      fetch(32'h0000_0008, 32'h0021_0003, 0, 1'b0, 6'h00);
      fetch(32'h0000_000C, 32'h0031_0003, 0, 1'b0, 6'h00);
      fetch(32'h0000_000B, 32'h0021_0003, 0, 1'b0, 6'h00);
      fetch(32'hFFFF_FC04, 32'h0011_0003, 0, 1'b0, 6'h00);

      // Conflict on index 0
      fetch(32'h0000_0080, 32'h0201_0003, 5, 1'b1, 6'h08);
      fetch(32'h0000_0000, 32'h0001_0003, 5, 1'b1, 6'h00);

      // Loop 0x000..0x020, then 0x004..0x020 twice: three fills only
      lat = 2;
      do_reset();
      for (int it = 0; it < 3; it++) begin
         for (int a = (it == 0) ? 0 : 4; a <= 32; a += 4) begin
            pa   = 32'(a);
            miss = (it == 0) && (a % 16 == 0);
            fetch(pa, mem_word(pa[9:2]), miss ? 4 : 0, miss, pa[9:4]);
         end
      end

      // Reset in the second FETCH cycle aborts the fill
      lat = 4;
      do_reset();
      fill_q.push_back(6'h00);
      pc = 32'h0;
      wait_mem_read();
      @(posedge clk);
      #2;
      check("mid_fetch_read", 64'(mem_read), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_mem_read", 64'(mem_read), 64'd0);
      check("abort_mem_addr", 64'(mem_address), 64'd0);
      check("abort_busywait", 64'(busywait), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fetch(32'h0000_0000, 32'h0001_0003, 6, 1'b1, 6'h00);

      // PC wanders during FETCH; the latched block is what gets filled
      fill_q.push_back(6'h05);
      pc = 32'h0000_0050;
      wait_mem_read();
      pc = 32'h0000_03F0;
      @(posedge clk);
      #1;
      check("latched_addr", 64'(mem_address), 64'h05);
      pc = 32'h0000_0050;
      repeat (6) @(posedge clk);
      #1;
      fetch(32'h0000_0054, 32'h0151_0003, 0, 1'b0, 6'h00);

      // Single-cycle memory and back-to-back misses on one index
      lat = 1;
      do_reset();
      fetch(32'h0000_0040, 32'h0101_0003, 3, 1'b1, 6'h04);
      fetch(32'h0000_03FC, 32'h0FF1_0003, 3, 1'b1, 6'h3F);
      fetch(32'h0000_0100, 32'h0401_0003, 3, 1'b1, 6'h10);
      fetch(32'h0000_0180, 32'h0601_0003, 3, 1'b1, 6'h18);
      fetch(32'h0000_0100, 32'h0401_0003, 3, 1'b1, 6'h10);
      fetch(32'h0000_0044, 32'h0111_0003, 0, 1'b0, 6'h00);

      repeat (3) @(posedge clk);
      check("fills_outstanding", 64'(fill_q.size()), 64'd0);
      check("resp_outstanding", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
